window_generator: RTL



---
 rtl/window_generator_if.sv | 12 +
 rtl/window_generator.sv | 113 +++++++++++
 2 files changed

// File: rtl/window_generator_if.sv
// Window bus between the raster pixel source and the filter stage.
// The master drives the pixel stream and flush; the slave presents the window.
interface window_generator_if #(
    parameter int Ope_Size = 3
);
    logic                               reflesh;
    logic [8:0]                         pixel_in;
    logic [9*Ope_Size*Ope_Size-1:0]     data_bus;

    modport master (output reflesh, output pixel_in, input data_bus);
    modport slave  (input reflesh, input pixel_in, output data_bus);
endinterface

// File: rtl/window_generator.sv
// Sliding Ope_Size x Ope_Size window over a raster pixel stream, with line buffers
// holding the previous Ope_Size-1 rows and a one-cycle window-valid pulse.

module window_row #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        new_px,
    output logic [N-1:0][7:0] taps
);
    // Column N-1 takes the incoming pixel; every other column takes its right neighbour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            taps <= '0;
        else if (clr)
            taps <= '0;
        else if (en)
            taps <= {new_px, taps[N-1:1]};
    end
endmodule

module window_generator #(
    parameter int Ope_Size = 3,
    parameter int Width    = 640,
    parameter int Height   = 480
) (
    input  logic               clk,
    input  logic               rst,
    window_generator_if.slave  bus
);
    localparam int N  = Ope_Size;
    localparam int CW = $clog2(Width);
    localparam int RW = $clog2(Height);

    typedef struct packed {
        logic       vld;
        logic [7:0] pix;
    } px_t;

    px_t                     px_in;
    logic                    accept;
    logic                    win_qual;
    logic                    win_valid;
    logic [CW-1:0]           col_cnt;
    logic [RW-1:0]           row_cnt;
    logic [N-1:0][7:0]       col_vec;
    logic [N-1:0][N-1:0][7:0] win;
    logic [7:0]              lb [N-1][Width];

    assign px_in    = bus.pixel_in;
    assign accept   = px_in.vld & ~bus.reflesh;
    assign win_qual = accept && (row_cnt >= RW'(N-1)) && (col_cnt >= CW'(N-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (bus.reflesh) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_cnt == CW'(Width-1)) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == RW'(Height-1)) ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Read-before-write: the column vector uses the old contents, buffers then shift down a line.
    always_comb begin
        col_vec        = '0;
        col_vec[N-1]   = px_in.pix;
        for (int k = 0; k < N-1; k++)
            col_vec[N-2-k] = lb[k][col_cnt];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][col_cnt] <= px_in.pix;
            for (int k = 1; k < N-1; k++)
                lb[k][col_cnt] <= lb[k-1][col_cnt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            win_valid <= 1'b0;
        else
            win_valid <= win_qual;
    end

    genvar y, x;
    generate
        for (y = 0; y < N; y++) begin : g_row
            window_row #(.N(N)) u_row (
                .clk    (clk),
                .rst    (rst),
                .clr    (bus.reflesh),
                .en     (accept),
                .new_px (col_vec[y]),
                .taps   (win[y])
            );
            for (x = 0; x < N; x++) begin : g_col
                assign bus.data_bus[((y*N)+x)*9 +: 9] = {win_valid, win[y][x]};
            end
        end
    endgenerate
endmodule
